// File: rtl/complex_to_pixel_if.sv
// Request/result bundle for complex_to_pixel.
//   master : requester side (drives the point, view and out_ready)
//   slave  : complex_to_pixel side (drives in_ready and the pixel result)
// Request : in_valid/in_ready, real_part, im_part, real_center, imag_center,
//           ZOOM, SCREEN_WIDTH, SCREEN_HEIGHT
// Result  : out_valid/out_ready, x, y, in_bounds
interface complex_to_pixel_if #(
  parameter int WORD_LENGTH = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_LENGTH-1:0] real_part;
  logic [WORD_LENGTH-1:0] im_part;
  logic [WORD_LENGTH-1:0] real_center;
  logic [WORD_LENGTH-1:0] imag_center;
  logic [31:0]            ZOOM;
  logic [31:0]            SCREEN_WIDTH;
  logic [31:0]            SCREEN_HEIGHT;
  logic                   out_valid;
  logic                   out_ready;
  logic [10:0]            x;
  logic [10:0]            y;
  logic                   in_bounds;

  modport master (
    output in_valid, real_part, im_part, real_center, imag_center,
           ZOOM, SCREEN_WIDTH, SCREEN_HEIGHT, out_ready,
    input  in_ready, out_valid, x, y, in_bounds
  );

  modport slave (
    input  in_valid, real_part, im_part, real_center, imag_center,
           ZOOM, SCREEN_WIDTH, SCREEN_HEIGHT, out_ready,
    output in_ready, out_valid, x, y, in_bounds
  );
endinterface

// File: rtl/complex_to_pixel.sv
// complex_to_pixel
// Maps a fixed-point complex point (Q(WL-FRAC).FRAC) back to screen pixel
// coordinates under the current center/zoom view, for cursor and overlay
// placement. One request in flight; x needs a divide by 3, done with a
// restoring divider producing one quotient bit per cycle.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : complex_to_pixel_if.slave (request valid/ready, result valid/ready)
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// MUL   | scale the offsets by zoom and screen size, capture y and range flags
// DIV   | QBITS cycles of restoring divide Sx/3, MSB first
// DONE  | result presented, held until out_ready
module complex_to_pixel #(
  parameter int WORD_LENGTH = 64,
  parameter int FRAC        = 60,
  parameter int QBITS       = 12
) (
  input logic          clk,
  input logic          rst,
  complex_to_pixel_if.slave bus
);

  localparam int NW  = WORD_LENGTH + 32;
  localparam int CW  = (QBITS > 1) ? $clog2(QBITS) : 1;
  localparam int XYW = 11;

  localparam logic signed [NW-1:0] ONE       = {{(NW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [NW-1:0] THREE_ONE = ONE + (ONE <<< 1);
  localparam logic signed [NW-1:0] SX_LIMIT  = {{(NW-2){1'b0}}, 2'b11} << QBITS;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [WORD_LENGTH-1:0] rp_q, ip_q, rc_q, ic_q;
  logic [31:0]            zoom_q, w_q, h_q;

  logic [CW-1:0]    cnt;
  logic [1:0]       rem_q;
  logic [QBITS-1:0] dvd_q;
  logic [QBITS-2:0] quo_q;
  logic [XYW-1:0]   y_q;
  logic             pre_ok_q;

  logic [XYW-1:0]   x_o, y_o;
  logic             inb_o;

  logic accept;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.x         = x_o;
  assign bus.y         = y_o;
  assign bus.in_bounds = inb_o;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scaling stage. Everything is widened to NW signed so the zoom/size
  // products cannot overflow for legal ZOOM, W and H.
  logic signed [NW-1:0] d_re, d_im, zoom_n, w_n, h_n, nx, ny, sx, sy;
  logic                 pre_ok;

  always_comb begin
    d_re   = {{32{rp_q[WORD_LENGTH-1]}}, rp_q} - {{32{rc_q[WORD_LENGTH-1]}}, rc_q};
    d_im   = {{32{ic_q[WORD_LENGTH-1]}}, ic_q} - {{32{ip_q[WORD_LENGTH-1]}}, ip_q};
    zoom_n = {{WORD_LENGTH{1'b0}}, zoom_q};
    w_n    = {{WORD_LENGTH{1'b0}}, w_q};
    h_n    = {{WORD_LENGTH{1'b0}}, h_q};
    nx     = ((d_re * zoom_n * w_n) <<< 1) + (THREE_ONE * w_n);
    ny     = (d_im * zoom_n * h_n) + (ONE * h_n);
    sx     = nx >>> (FRAC + 1);
    sy     = ny >>> (FRAC + 1);
    // x < W still has to wait for the quotient
    pre_ok = !nx[NW-1] && !ny[NW-1] && (sx < SX_LIMIT) && (sy < h_n) && (zoom_q != '0);
  end

  // One restoring-divide step. With Sx < 3*2^QBITS the two bits above the
  // quotient field start the partial remainder below 3, so QBITS steps
  // produce the whole quotient. Out-of-range Sx gives garbage that the
  // bounds flag masks.
  logic [2:0]       trial;
  logic             qbit;
  logic [1:0]       rem_nxt;
  logic [QBITS-1:0] quo_nxt;
  logic             in_b;

  always_comb begin
    trial   = {rem_q, dvd_q[QBITS-1]};
    qbit    = (trial >= 3'd3);
    rem_nxt = qbit ? 2'(trial - 3'd3) : trial[1:0];
    quo_nxt = {quo_q, qbit};
    in_b    = pre_ok_q && (32'(quo_nxt) < w_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q     <= '0;
      ip_q     <= '0;
      rc_q     <= '0;
      ic_q     <= '0;
      zoom_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cnt      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      y_q      <= '0;
      pre_ok_q <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
      inb_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rp_q   <= bus.real_part;
            ip_q   <= bus.im_part;
            rc_q   <= bus.real_center;
            ic_q   <= bus.imag_center;
            zoom_q <= bus.ZOOM;
            w_q    <= bus.SCREEN_WIDTH;
            h_q    <= bus.SCREEN_HEIGHT;
          end
        end
        MUL: begin
          rem_q    <= sx[QBITS+1:QBITS];
          dvd_q    <= sx[QBITS-1:0];
          quo_q    <= '0;
          y_q      <= sy[XYW-1:0];
          pre_ok_q <= pre_ok;
          cnt      <= CW'(QBITS - 1);
        end
        DIV: begin
          rem_q <= rem_nxt;
          dvd_q <= dvd_q << 1;
          quo_q <= quo_nxt[QBITS-2:0];
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            x_o   <= in_b ? quo_nxt[XYW-1:0] : '0;
            y_o   <= in_b ? y_q : '0;
            inb_o <= in_b;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_to_pixel.sv
// Scoreboard bench for complex_to_pixel: directed points with hand-computed
// pixels are queued at accept time; a negedge monitor checks every cycle the
// result is presented and pops on handshake.
module tb_complex_to_pixel;

  localparam longint ONE_F  = 64'sh1000_0000_0000_0000;  // 1.0
  localparam longint HALF   = 64'sh0800_0000_0000_0000;  // 0.5
  localparam longint TWO    = 64'sh2000_0000_0000_0000;  // 2.0
  localparam longint P1_25  = 64'sh1400_0000_0000_0000;  // 1.25
  localparam longint P0_3125 = 64'sh0500_0000_0000_0000; // 0.3125
  localparam int     LAT    = 14;

  typedef struct {
    int     x;
    int     y;
    int     inb;
    int     tol;
    longint acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     prev_v = 1'b0;
  exp_t   sb[$];

  longint cur_rc, cur_ic;
  int     cur_w, cur_h;

  complex_to_pixel_if #(.WORD_LENGTH(64)) bus ();

  complex_to_pixel #(
    .WORD_LENGTH(64),
    .FRAC(60),
    .QBITS(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d +/- %0d (cycle %0d)", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: compare every cycle the DUT presents a result; latency is the
  // number of edges from the accepting edge to the first edge that sees
  // out_valid high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got out_valid=1, required 0 (cycle %0d)", cyc);
        end else begin
          e = sb[0];
          if (!prev_v) check("latency", cyc + 1 - e.acc, LAT);
          check_tol("x", longint'(bus.x), e.x, e.tol);
          check_tol("y", longint'(bus.y), e.y, e.tol);
          check("in_bounds", longint'(bus.in_bounds), e.inb);
          check("in_ready_busy", longint'(bus.in_ready), 0);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      prev_v = bus.out_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic drive_req(input longint rp, input longint ip, input int z);
    bus.real_part     = rp;
    bus.im_part       = ip;
    bus.real_center   = cur_rc;
    bus.imag_center   = cur_ic;
    bus.ZOOM          = z;
    bus.SCREEN_WIDTH  = cur_w;
    bus.SCREEN_HEIGHT = cur_h;
    bus.in_valid      = 1'b1;
  endtask

  task automatic send(input longint rp, input longint ip, input int z,
                      input int ex, input int ey, input int einb, input int tol,
                      input bit push);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(posedge clk);
    #1;
    drive_req(rp, ip, z);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      e.x = ex; e.y = ey; e.inb = einb; e.tol = tol; e.acc = cyc + 1;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 0);
  endtask

  // Render-path pixel->complex: x spans 3/ZOOM real units, y spans 2/ZOOM.
  function automatic longint px_to_re(input int px);
    logic signed [127:0] num, den, q;
    num = 3 * (2 * px - cur_w);
    num = num <<< 60;
    den = 2 * cur_w;
    q   = num / den;
    return cur_rc + longint'(q[63:0]);
  endfunction

  function automatic longint py_to_im(input int py);
    logic signed [127:0] num, den, q;
    num = 2 * py - cur_h;
    num = num <<< 60;
    den = cur_h;
    q   = num / den;
    return cur_ic - longint'(q[63:0]);
  endfunction

  initial begin
    exp_t e;
    bit   seen;
    int   rx, ry;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.real_part = '0;
    bus.im_part = '0;
    bus.real_center = '0;
    bus.imag_center = '0;
    bus.ZOOM = '0;
    bus.SCREEN_WIDTH = '0;
    bus.SCREEN_HEIGHT = '0;
    cur_rc = -HALF;
    cur_ic = 0;
    cur_w  = 960;
    cur_h  = 720;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_x", longint'(bus.x), 0);
    check("rst_y", longint'(bus.y), 0);
    check("rst_in_bounds", longint'(bus.in_bounds), 0);
    check("rst_in_ready", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", longint'(bus.in_ready), 1);

    // Center, corners, edges, plain interior point, zero zoom
    send(-HALF, 0, 1, 480, 360, 1, 0, 1'b1);
    send(-TWO, ONE_F, 1, 0, 0, 1, 0, 1'b1);
    send(ONE_F, 0, 1, 0, 0, 0, 0, 1'b1);
    send(-HALF, -ONE_F, 1, 0, 0, 0, 0, 1'b1);
    send(-P1_25, HALF, 1, 240, 180, 1, 0, 1'b1);
    send(-HALF, 0, 0, 0, 0, 0, 0, 1'b1);
    // Zoom 4: offset 0.1875 -> x = 480 + 0.1875*4*320
    send(-P0_3125, 0, 4, 720, 360, 1, 0, 1'b1);
    send(-TWO, 0, 4, 0, 0, 0, 0, 1'b1);
    wait_idle();

    // Backpressure: result held 20 cycles, then next request accepted the
    // cycle after the handshake
    bus.out_ready = 1'b0;
    send(-HALF, 0, 1, 480, 360, 1, 0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", longint'(seen), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_valid", longint'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drive_req(-P1_25, HALF, 1);
    @(negedge clk);
    check("bp_in_ready_done", longint'(bus.in_ready), 0);
    @(negedge clk);
    check("bp_in_ready_next", longint'(bus.in_ready), 1);
    if (bus.in_ready) begin
      e.x = 240; e.y = 180; e.inb = 1; e.tol = 0; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of the divide: request dropped, outputs cleared
    send(-HALF, 0, 1, 0, 0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", longint'(bus.in_ready), 1);
    check("post_rst_out_valid", longint'(bus.out_valid), 0);
    check("post_rst_x", longint'(bus.x), 0);
    check("post_rst_y", longint'(bus.y), 0);
    check("post_rst_in_bounds", longint'(bus.in_bounds), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", longint'(bus.out_valid), 0);
    end

    // Round trip through the render mapping
    for (int i = 0; i < 6; i++) begin
      rx = $urandom_range(cur_w - 2, 1);
      ry = $urandom_range(cur_h - 2, 1);
      send(px_to_re(rx), py_to_im(ry), 1, rx, ry, 1, 1, 1'b1);
    end
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
